timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel memory-mapped timer on the IO bus; the successor to the single stopwatch peripheral. It provides NUM_CH independent WIDTH-bit counters driven by one shared prescaler tick. Each channel has software enable, clear, a compare register, free-run/periodic/one-shot modes, sticky match and overflow flags, and an interrupt contribution. It runs entirely in the iCLK domain; no second clock and no asynchronous reset.

## Interface
- NUM_CH, 4, number of timer channels (1..16)
- WIDTH, 32, counter and compare width (8..32); register reads zero-extend to 32 bits
- PRESCALE, 50000, iCLK cycles per tick (≥1; 50000 gives 1 ms at 50 MHz)
- BASE_ADDR, STOPWATCH_ADDRESS, byte address of channel 0
- iCLK  in  1  system clock; all logic on the rising edge
- iRST  in  1  reset; synchronous, active-high
- wReadEnable  in  1  bus read strobe
- wWriteEnable  in  1  bus write strobe
- wByteEnable  in  4  write byte lanes; bit i enables wWriteData[8i+7:8i]
- wAddress  in  32  byte address
- wWriteData  in  32  write data
- wReadData  out  32  read data; 32'hzzzzzzzz when not selected
- oIRQ  out  1  OR over channels of (MATCH & IRQ_EN); registered

## Operation
- Channel c occupies BASE_ADDR + 16·c; word offsets are CTRL 0x0, COUNT 0x4, COMPARE 0x8, STATUS 0xC.
- Addresses outside BASE_ADDR .. BASE_ADDR+16·NUM_CH−1, or not word-aligned, are not selected.
- CTRL bits:
  - [0] EN
  - [1] PERIODIC
  - [2] ONESHOT
  - [3] IRQ_EN
  - [4] CLEAR: write-only and self-clearing; writing 1 zeroes COUNT. It always reads 0.
  - Other bits read 0.
- COUNT and COMPARE are read/write. Writes honour wByteEnable and are truncated to WIDTH.
- STATUS bits:
  - [0] MATCH: sticky.
  - [1] OVF: sticky.
  - Writing 1 to a bit clears it (W1C); writing 0 has no effect.
- Prescaler: a counter runs 0..PRESCALE−1 and wraps. Tick is asserted for one cycle when the counter equals PRESCALE−1. With PRESCALE=1, tick is asserted every cycle.
- On a tick with EN=1:
  - If COUNT == COMPARE:
    - Set MATCH.
    - COUNT ← 0 if PERIODIC, else COUNT+1.
    - If ONESHOT, clear EN.
  - Otherwise COUNT ← COUNT+1.
  - If COUNT is all-ones and is incremented, it wraps to 0 and sets OVF.
- Precedence within one cycle, highest first:
  1. Reset.
  2. Bus write to COUNT, or CLEAR. The written value is loaded and the tick increment is discarded.
  3. Tick update.
- Flag set versus W1C in the same cycle: the set wins and the flag stays 1.
- CTRL write in the same cycle as a one-shot match: the written EN value wins.
- Reads are combinational (zero latency) and return the register state before the current edge.
- wReadData is z when wReadEnable=0 or the address is unselected.
- Writes with wWriteEnable=0 have no effect.

## Timing
- Reset (iRST=1 at an edge) sets every COUNT, COMPARE, CTRL, STATUS, the prescaler counter and oIRQ to 0 on that edge.
- Reset mid-count discards any pending tick.
- Bus write latency: the register updates at the edge where wWriteEnable=1; a read in the next cycle returns the new value.
- Tick-to-COUNT latency: 1 cycle. COUNT changes at the edge where tick=1.
- MATCH sets at that same edge.
- oIRQ asserts one cycle after MATCH and IRQ_EN are both 1, and deasserts one cycle after the W1C.
- First tick after reset or after a write: the prescaler is free-running and is not restarted by register writes.
  - Reset releases at edge 0; the first tick is at edge PRESCALE.

## Structure
- Package timer_bank_pkg holds:
  - register offsets (CTRL/COUNT/COMPARE/STATUS)
  - CTRL and STATUS bit indices
  - a ctrl_t packed struct
- Sub-module timer_channel (one per channel, via generate) holds:
  - COUNT, COMPARE, CTRL and STATUS
  - tick, write-decode and W1C inputs
  - a read mux output and an irq output
- Top level holds:
  - the prescaler
  - address decode
  - the read mux with tri-state
  - the oIRQ OR-reduce register

## Test plan
- Reset and defaults: PRESCALE=1; assert iRST mid-count with COUNT=0x55 → all registers read 0 and oIRQ=0 on the next cycle. An unmapped address reads 32'hzzzzzzzz.
- Free-run with prescaler: PRESCALE=4; EN=1 at ch0 → COUNT reads 5 after 20 cycles. Disable (EN=0) → COUNT holds 5.
- Periodic match and IRQ: COMPARE=3, CTRL=PERIODIC|IRQ_EN|EN, PRESCALE=1 → COUNT sequence 0,1,2,3,0,…; MATCH sets on the 3→0 edge; oIRQ is high the cycle after. W1C STATUS=1 → oIRQ low the next cycle.
- One-shot: COMPARE=2, CTRL=ONESHOT|EN → EN reads 0 after the match and COUNT stays 3.
- Wrap and overflow: WIDTH=8, COUNT write 0xFF, EN=1 → COUNT=0x00 and OVF=1. A byte-enable write 4'b0001 of 0xAABBCC12 to COMPARE → COMPARE reads 0x12.
- Collisions:
  - Tick and COUNT write 0x40 in the same cycle → COUNT=0x40.
  - MATCH set and W1C in the same cycle → MATCH stays 1.
  - Channels 0 and 3 configured differently → no cross-talk.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - register map, bit indices and shared types for timer_bank
package timer_bank_pkg;

    localparam logic [31:0] STOPWATCH_ADDRESS = 32'h8000_0100;

    // Word offset within a channel's 16-byte window, i.e. address bits [3:2]
    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_off_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_ONESHOT  = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_CLEAR    = 4;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

    // Member order places en at bit 0 so the struct lines up with CTRL[3:0]
    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: COUNT, COMPARE, CTRL, STATUS and its irq contribution
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        wr_sel,
    input  reg_off_e    off,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;

    logic match_set, ovf_set, match_w1c, ovf_w1c;

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        match_set = 1'b0;
        ovf_set   = 1'b0;
        match_w1c = 1'b0;
        ovf_w1c   = 1'b0;

        if (tick && ctrl_q.en) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q.oneshot) begin
                    ctrl_d.en = 1'b0;
                end
            end
            if ((count_q == compare_q) && ctrl_q.periodic) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
                ovf_set = &count_q;
            end
        end

        // Bus writes override the tick result; only the flag sets survive a collision
        if (wr_sel) begin
            case (off)
                REG_CTRL: begin
                    if (wr_be[0]) begin
                        ctrl_d = ctrl_t'(wr_data[3:0]);
                        if (wr_data[CTRL_CLEAR]) begin
                            count_d = '0;
                        end
                    end
                end
                REG_COUNT: begin
                    count_d = WIDTH'(merge_bytes(32'(count_q), wr_data, wr_be));
                end
                REG_COMPARE: begin
                    compare_d = WIDTH'(merge_bytes(32'(compare_q), wr_data, wr_be));
                end
                default: begin
                    if (wr_be[0]) begin
                        match_w1c = wr_data[STAT_MATCH];
                        ovf_w1c   = wr_data[STAT_OVF];
                    end
                end
            endcase
        end

        match_d = (match_q & ~match_w1c) | match_set;
        ovf_d   = (ovf_q & ~ovf_w1c) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            REG_CTRL:    rd_data = 32'(ctrl_q);
            REG_COUNT:   rd_data = 32'(count_q);
            REG_COMPARE: rd_data = 32'(compare_q);
            default: begin
                rd_data[STAT_MATCH] = match_q;
                rd_data[STAT_OVF]   = ovf_q;
            end
        endcase
    end

    assign irq = match_q & ctrl_q.irq_en;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel memory-mapped timer with shared prescaler and registered irq
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter int          PRESCALE  = 50000,
    parameter logic [31:0] BASE_ADDR = STOPWATCH_ADDRESS
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        wReadEnable,
    input  logic        wWriteEnable,
    input  logic [3:0]  wByteEnable,
    input  logic [31:0] wAddress,
    input  logic [31:0] wWriteData,
    output logic [31:0] wReadData,
    output logic        oIRQ
);

    localparam int          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(16 * NUM_CH);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;
    logic [31:0]       offset;
    logic              sel;
    logic [3:0]        ch_idx;
    reg_off_e          off;
    logic [NUM_CH-1:0] irq_ch;
    logic [31:0]       rd_ch [NUM_CH];
    logic [31:0]       rd_word;
    logic              irq_q, irq_d;

    // Free-running prescaler; register writes never restart it
    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        offset = wAddress - BASE_ADDR;
        sel    = (wAddress >= BASE_ADDR) && ({1'b0, wAddress} < END_ADDR)
                 && (wAddress[1:0] == 2'b00);
        ch_idx = 4'(offset >> 4);
        off    = reg_off_e'(2'(offset >> 2));
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ch_we;
        assign ch_we = wWriteEnable && sel && (ch_idx == 4'(c));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (iCLK),
            .rst     (iRST),
            .tick    (tick),
            .wr_sel  (ch_we),
            .off     (off),
            .wr_data (wWriteData),
            .wr_be   (wByteEnable),
            .rd_data (rd_ch[c]),
            .irq     (irq_ch[c])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
                rd_word = rd_ch[c];
            end
        end
        irq_d = |irq_ch;
    end

    assign wReadData = (wReadEnable && sel) ? rd_word : 32'hzzzz_zzzz;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            presc_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            irq_q   <= irq_d;
        end
    end

    assign oIRQ = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - randomized and directed checks of timer_bank against a cycle model
module tb_timer_bank;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        wReadEnable = 1'b0;
    logic        wWriteEnable = 1'b0;
    logic [3:0]  wByteEnable = 4'h0;
    logic [31:0] wAddress = 32'h0;
    logic [31:0] wWriteData = 32'h0;
    wire  [31:0] rd0, rd1, rd2;
    wire         irq0, irq1, irq2;

    always #5 iCLK = ~iCLK;

    timer_bank #(.NUM_CH(4), .WIDTH(32), .PRESCALE(1), .BASE_ADDR(32'h1000)) u_dut0 (
        .iCLK(iCLK), .iRST(iRST), .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable),
        .wByteEnable(wByteEnable), .wAddress(wAddress), .wWriteData(wWriteData),
        .wReadData(rd0), .oIRQ(irq0));
    timer_bank #(.NUM_CH(4), .WIDTH(32), .PRESCALE(4), .BASE_ADDR(32'h2000)) u_dut1 (
        .iCLK(iCLK), .iRST(iRST), .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable),
        .wByteEnable(wByteEnable), .wAddress(wAddress), .wWriteData(wWriteData),
        .wReadData(rd1), .oIRQ(irq1));
    timer_bank #(.NUM_CH(4), .WIDTH(8), .PRESCALE(1), .BASE_ADDR(32'h3000)) u_dut2 (
        .iCLK(iCLK), .iRST(iRST), .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable),
        .wByteEnable(wByteEnable), .wAddress(wAddress), .wWriteData(wWriteData),
        .wReadData(rd2), .oIRQ(irq2));

    logic [31:0] base [3] = '{32'h1000, 32'h2000, 32'h3000};
    int          pre  [3] = '{1, 4, 1};
    int          wid  [3] = '{32, 32, 8};

    logic [31:0] m_cnt [3][4], n_cnt [3][4];
    logic [31:0] m_cmp [3][4], n_cmp [3][4];
    logic [3:0]  m_ctl [3][4], n_ctl [3][4];
    logic [1:0]  m_sts [3][4], n_sts [3][4];
    int          m_presc [3], n_presc [3];
    logic        m_irq [3], n_irq [3];

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] last_rd;
    logic        last_irq;

    // Advance one clock: predict from the current bus inputs, then let both sides take the edge
    task automatic tick_cycle();
        logic [31:0] mask, cnt, cmp, bm, rel;
        logic [1:0]  clr, setf;
        logic        tk;
        for (int i = 0; i < 3; i++) begin
            mask = (wid[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[i]) - 32'd1);
            if (iRST) begin
                for (int c = 0; c < 4; c++) begin
                    n_cnt[i][c] = 0; n_cmp[i][c] = 0; n_ctl[i][c] = 0; n_sts[i][c] = 0;
                end
                n_presc[i] = 0;
                n_irq[i]   = 1'b0;
            end else begin
                tk = (m_presc[i] == pre[i] - 1);
                n_presc[i] = (m_presc[i] + 1) % pre[i];
                n_irq[i] = 1'b0;
                for (int c = 0; c < 4; c++)
                    if (m_sts[i][c][0] && m_ctl[i][c][3]) n_irq[i] = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    cnt = m_cnt[i][c];
                    cmp = m_cmp[i][c];
                    n_cnt[i][c] = cnt;
                    n_cmp[i][c] = cmp;
                    n_ctl[i][c] = m_ctl[i][c];
                    setf = 2'b00;
                    clr  = 2'b00;
                    if (tk && m_ctl[i][c][0]) begin
                        if (cnt == cmp) begin
                            setf[0] = 1'b1;
                            if (m_ctl[i][c][2]) n_ctl[i][c][0] = 1'b0;
                        end
                        if (cnt == cmp && m_ctl[i][c][1]) begin
                            n_cnt[i][c] = 0;
                        end else begin
                            n_cnt[i][c] = (cnt + 1) & mask;
                            if (cnt == mask) setf[1] = 1'b1;
                        end
                    end
                    rel = wAddress - base[i];
                    if (wWriteEnable && wAddress >= base[i] && rel < 64 && rel[1:0] == 2'b00
                        && (rel >> 4) == c) begin
                        bm = {{8{wByteEnable[3]}}, {8{wByteEnable[2]}},
                              {8{wByteEnable[1]}}, {8{wByteEnable[0]}}};
                        case (rel[3:0])
                            4'h0: if (wByteEnable[0]) begin
                                n_ctl[i][c] = wWriteData[3:0];
                                if (wWriteData[4]) n_cnt[i][c] = 0;
                            end
                            4'h4: n_cnt[i][c] = ((cnt & ~bm) | (wWriteData & bm)) & mask;
                            4'h8: n_cmp[i][c] = ((cmp & ~bm) | (wWriteData & bm)) & mask;
                            default: if (wByteEnable[0]) clr = wWriteData[1:0];
                        endcase
                    end
                    n_sts[i][c] = (m_sts[i][c] & ~clr) | setf;
                end
            end
        end
        @(posedge iCLK);
        m_cnt = n_cnt; m_cmp = n_cmp; m_ctl = n_ctl; m_sts = n_sts;
        m_presc = n_presc; m_irq = n_irq;
        @(negedge iCLK);
    endtask

    function automatic logic [31:0] model_read(input int i, input logic [31:0] a, input logic ren);
        logic [31:0] rel;
        int c;
        rel = a - base[i];
        if (!ren || a < base[i] || rel >= 64 || rel[1:0] != 2'b00) return 32'hzzzz_zzzz;
        c = int'(rel >> 4);
        case (rel[3:0])
            4'h0:    return {28'h0, m_ctl[i][c]};
            4'h4:    return m_cnt[i][c];
            4'h8:    return m_cmp[i][c];
            default: return {30'h0, m_sts[i][c]};
        endcase
    endfunction

    task automatic rd_check(input int i, input logic [31:0] a, input logic ren, input string name);
        logic [31:0] exp;
        wWriteEnable = 1'b0;
        wAddress     = a;
        wReadEnable  = ren;
        #1;
        exp      = model_read(i, a, ren);
        last_rd  = (i == 0) ? rd0 : (i == 1) ? rd1 : rd2;
        last_irq = (i == 0) ? irq0 : (i == 1) ? irq1 : irq2;
        vectors++;
        if (last_rd !== exp) begin
            errors++;
            $display("FAIL %s rd[%0d] @%h: got %h expected %h", name, i, a, last_rd, exp);
        end
        vectors++;
        if (last_irq !== m_irq[i]) begin
            errors++;
            $display("FAIL %s oIRQ[%0d]: got %b expected %b", name, i, last_irq, m_irq[i]);
        end
        tick_cycle();
        wReadEnable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wReadEnable  = 1'b0;
        wAddress     = a;
        wWriteData   = d;
        wByteEnable  = be;
        wWriteEnable = 1'b1;
        tick_cycle();
        wWriteEnable = 1'b0;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick_cycle();
        iRST = 1'b0;
    endtask

    task automatic const_check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        wr(32'h1004, 32'h55, 4'hF);
        wr(32'h1000, 32'h9, 4'hF);
        wr(32'h1008, 32'h57, 4'hF);
        repeat (3) tick_cycle();
        iRST = 1'b1;
        tick_cycle();
        iRST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int o = 0; o < 4; o++) begin
                rd_check(0, 32'h1000 + 32'(16 * c + 4 * o), 1'b1, "reset_reg");
                const_check("reset_zero", last_rd, 32'h0);
            end
        end
        const_check("reset_irq", {31'h0, last_irq}, 32'h0);
        rd_check(0, 32'h1040, 1'b1, "unmapped_hi");
        const_check("unmapped_z", last_rd, 32'hzzzz_zzzz);
        rd_check(0, 32'h1002, 1'b1, "misaligned");
        rd_check(0, 32'h0FFC, 1'b1, "unmapped_lo");
        rd_check(0, 32'h1004, 1'b0, "read_disabled");
    endtask

    task automatic test_prescale();
        do_reset();
        wr(32'h2000, 32'h1, 4'hF);
        repeat (19) tick_cycle();
        rd_check(1, 32'h2004, 1'b1, "prescale_count");
        const_check("prescale_count5", last_rd, 32'd5);
        wr(32'h2000, 32'h0, 4'hF);
        repeat (10) tick_cycle();
        rd_check(1, 32'h2004, 1'b1, "prescale_hold");
        const_check("prescale_hold5", last_rd, 32'd5);
    endtask

    task automatic test_periodic();
        do_reset();
        wr(32'h1008, 32'h3, 4'hF);
        wr(32'h1000, 32'hB, 4'hF);
        for (int k = 0; k < 10; k++) begin
            rd_check(0, 32'h1004, 1'b1, "periodic_count");
            const_check("periodic_seq", last_rd, 32'(k % 4));
        end
        rd_check(0, 32'h100C, 1'b1, "periodic_match");
        wr(32'h1000, 32'h8, 4'hF);
        wr(32'h100C, 32'h1, 4'hF);
        rd_check(0, 32'h100C, 1'b1, "w1c_status");
        rd_check(0, 32'h100C, 1'b1, "w1c_irq_low");
        const_check("w1c_irq_zero", {31'h0, last_irq}, 32'h0);
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(32'h1018, 32'h2, 4'hF);
        wr(32'h1010, 32'h5, 4'hF);
        repeat (6) tick_cycle();
        rd_check(0, 32'h1010, 1'b1, "oneshot_ctrl");
        const_check("oneshot_en_off", last_rd, 32'h4);
        rd_check(0, 32'h1014, 1'b1, "oneshot_count");
        const_check("oneshot_count3", last_rd, 32'h3);
        rd_check(0, 32'h101C, 1'b1, "oneshot_match");
    endtask

    task automatic test_wrap();
        do_reset();
        wr(32'h3008, 32'hAABB_CC12, 4'b0001);
        rd_check(2, 32'h3008, 1'b1, "be_compare");
        const_check("be_compare12", last_rd, 32'h12);
        wr(32'h3004, 32'h0000_01FF, 4'hF);
        wr(32'h3000, 32'h1, 4'hF);
        rd_check(2, 32'h3004, 1'b1, "wrap_pre");
        const_check("wrap_ff", last_rd, 32'hFF);
        rd_check(2, 32'h3004, 1'b1, "wrap_post");
        const_check("wrap_00", last_rd, 32'h00);
        rd_check(2, 32'h300C, 1'b1, "ovf_flag");
        const_check("ovf_set", last_rd, 32'h2);
    endtask

    task automatic test_collisions();
        do_reset();
        wr(32'h1020, 32'h1, 4'hF);
        repeat (3) tick_cycle();
        wr(32'h1024, 32'h40, 4'hF);
        rd_check(0, 32'h1024, 1'b1, "tick_vs_write");
        const_check("tick_vs_write40", last_rd, 32'h40);
        wr(32'h1020, 32'h0, 4'hF);
        wr(32'h1024, 32'h10, 4'hF);
        wr(32'h1028, 32'h12, 4'hF);
        wr(32'h1020, 32'h1, 4'hF);
        repeat (2) tick_cycle();
        wr(32'h102C, 32'h1, 4'hF);
        rd_check(0, 32'h102C, 1'b1, "set_vs_w1c");
        const_check("set_vs_w1c_match", last_rd & 32'h1, 32'h1);
        do_reset();
        wr(32'h1008, 32'h5, 4'hF);
        wr(32'h1000, 32'h3, 4'hF);
        wr(32'h1038, 32'hFFFF, 4'hF);
        wr(32'h1030, 32'h1, 4'hF);
        repeat (12) tick_cycle();
        for (int o = 0; o < 4; o++) begin
            rd_check(0, 32'h1000 + 32'(4 * o), 1'b1, "xtalk_ch0");
            rd_check(0, 32'h1030 + 32'(4 * o), 1'b1, "xtalk_ch3");
        end
        rd_check(0, 32'h1014, 1'b1, "xtalk_ch1");
        const_check("xtalk_ch1_idle", last_rd, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        int          i, kind;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            i = $urandom_range(0, 2);
            a = base[i] + 32'($urandom_range(0, 4) * 16) + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 15) == 0) a = a + 32'd1;
            kind = $urandom_range(0, 63);
            if (kind == 0) begin
                do_reset();
            end else if (kind < 28) begin
                d = $urandom();
                if (a[3:0] == 4'h0) d = d & 32'h1F;
                if (a[3:0] == 4'h8 && $urandom_range(0, 1) == 1) d = d & 32'hF;
                wr(a, d, 4'($urandom_range(0, 15)));
            end else if (kind < 36) begin
                tick_cycle();
            end else begin
                rd_check(i, a, $urandom_range(0, 7) != 0, "random");
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 4; c++) begin
                m_cnt[i][c] = 0; m_cmp[i][c] = 0; m_ctl[i][c] = 0; m_sts[i][c] = 0;
            end
            m_presc[i] = 0;
            m_irq[i]   = 1'b0;
        end
        @(negedge iCLK);
        test_reset();
        test_prescale();
        test_periodic();
        test_oneshot();
        test_wrap();
        test_collisions();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
